// File: rtl/hazard_ctrl_md_pkg.sv
// hazard_ctrl_md_pkg: shared types and forwarding-select encodings for the hazard controller
package hazard_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;
endpackage

// File: rtl/hazard_ctrl_md_if.sv
// hazard_ctrl_md_if: pipeline-stage info in, forwarding/stall/flush controls out
interface hazard_ctrl_md_if #(parameter int RW = 5, parameter int CNT_W = 32);
  logic [RW-1:0] rs_d, rt_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w;
  logic branch_d, jr_d, regwrite_e, memtoreg_e, md_start_e, md_is_div_e;
  logic regwrite_m, memtoreg_m, regwrite_w, except_flush;
  logic fwd_a_d, fwd_b_d;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic stall_f, stall_d, stall_e, stall_m, stall_w;
  logic flush_d, flush_e, flush_m;
  logic md_busy, md_done;
  logic [CNT_W-1:0] stall_cnt;
  modport master (
    output rs_d, rt_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w, branch_d, jr_d, regwrite_e, memtoreg_e,
           md_start_e, md_is_div_e, regwrite_m, memtoreg_m, regwrite_w, except_flush,
    input  fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e, stall_f, stall_d, stall_e, stall_m, stall_w,
           flush_d, flush_e, flush_m, md_busy, md_done, stall_cnt
  );
  modport slave (
    input  rs_d, rt_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w, branch_d, jr_d, regwrite_e, memtoreg_e,
           md_start_e, md_is_div_e, regwrite_m, memtoreg_m, regwrite_w, except_flush,
    output fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e, stall_f, stall_d, stall_e, stall_m, stall_w,
           flush_d, flush_e, flush_m, md_busy, md_done, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl_md_seq.sv
// md_sequencer: tracks mul/div occupancy of E; busy for N cycles, then a one-cycle done
module md_sequencer import hazard_pkg::*; #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  input  logic is_div,
  input  logic kill,
  output logic busy,
  output logic done
);
  localparam int MAXC = MUL_CYCLES > DIV_CYCLES ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW = MAXC > 1 ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] MUL_LD = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LD = CW'(DIV_CYCLES - 1);
  md_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, ld;
  assign ld = is_div ? DIV_LD : MUL_LD;
  // The start cycle in IDLE already counts as one busy cycle, so BUSY leaves at cnt==1
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (kill) begin
      state_n = IDLE;
      cnt_n = '0;
    end else if (state == IDLE) begin
      state_n = start ? (ld == '0 ? DONE : BUSY) : IDLE;
      cnt_n = start ? ld : cnt;
    end else if (state == BUSY) begin
      state_n = cnt <= CW'(1) ? DONE : BUSY;
      cnt_n = cnt == '0 ? '0 : cnt - CW'(1);
    end else begin
      state_n = IDLE;
      cnt_n = '0;
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end
  assign busy = (state == IDLE && start) || state == BUSY;
  assign done = state == DONE && !kill;
endmodule

// File: rtl/hazard_ctrl_md.sv
// hazard_ctrl_md: forwarding, data-hazard stalls, mul/div busy and exception flush for the 5-stage core
module hazard_ctrl_md import hazard_pkg::*; #(
  parameter int RW = 5,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic resetn,
  hazard_ctrl_md_if.slave bus
);
  function automatic logic hit(input logic [RW-1:0] s, input logic [RW-1:0] d, input logic we);
    return we && s != '0 && s == d;
  endfunction
  logic lw, ctl, dstall, md_busy, ef;
  logic [CNT_W-1:0] cnt;
  assign ef = bus.except_flush;
  md_sequencer #(.MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES)) u_seq (
    .clk(clk), .resetn(resetn), .start(bus.md_start_e), .is_div(bus.md_is_div_e),
    .kill(ef), .busy(md_busy), .done(bus.md_done)
  );
  assign bus.md_busy = md_busy;
  assign bus.fwd_a_d = hit(bus.rs_d, bus.wreg_m, bus.regwrite_m);
  assign bus.fwd_b_d = hit(bus.rt_d, bus.wreg_m, bus.regwrite_m);
  assign bus.fwd_a_e = hit(bus.rs_e, bus.wreg_m, bus.regwrite_m) ? FWD_M :
                       hit(bus.rs_e, bus.wreg_w, bus.regwrite_w) ? FWD_W : FWD_RF;
  assign bus.fwd_b_e = hit(bus.rt_e, bus.wreg_m, bus.regwrite_m) ? FWD_M :
                       hit(bus.rt_e, bus.wreg_w, bus.regwrite_w) ? FWD_W : FWD_RF;
  assign lw = hit(bus.rs_d, bus.wreg_e, bus.memtoreg_e) || hit(bus.rt_d, bus.wreg_e, bus.memtoreg_e);
  // Branch/jump compare in D needs E's ALU result or M's load data, neither forwardable in time
  assign ctl = (bus.branch_d || bus.jr_d) &&
               (hit(bus.rs_d, bus.wreg_e, bus.regwrite_e) || hit(bus.rt_d, bus.wreg_e, bus.regwrite_e) ||
                hit(bus.rs_d, bus.wreg_m, bus.memtoreg_m) || hit(bus.rt_d, bus.wreg_m, bus.memtoreg_m));
  assign dstall = lw || ctl;
  assign bus.stall_f = !ef && (dstall || md_busy);
  assign bus.stall_d = !ef && (dstall || md_busy);
  assign bus.stall_e = !ef && md_busy;
  assign bus.stall_m = !ef && md_busy;
  assign bus.stall_w = !ef && md_busy;
  assign bus.flush_d = ef;
  assign bus.flush_e = ef || (dstall && !md_busy);
  assign bus.flush_m = ef;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt <= '0;
    else if (bus.stall_f && !(&cnt)) cnt <= cnt + CNT_W'(1);
  end
  assign bus.stall_cnt = cnt;
endmodule

// File: tb/tb_hazard_ctrl_md.sv
// tb_hazard_ctrl_md: directed checks of forwarding, stalls, mul/div sequencing, flush and stall counter
module tb_hazard_ctrl_md;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  hazard_ctrl_md_if #(.RW(5), .CNT_W(4)) bus ();
  hazard_ctrl_md #(.RW(5), .MUL_CYCLES(4), .DIV_CYCLES(32), .CNT_W(4)) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  task automatic clear_inputs;
    bus.rs_d = '0; bus.rt_d = '0; bus.rs_e = '0; bus.rt_e = '0;
    bus.wreg_e = '0; bus.wreg_m = '0; bus.wreg_w = '0;
    bus.branch_d = 0; bus.jr_d = 0; bus.regwrite_e = 0; bus.memtoreg_e = 0;
    bus.md_start_e = 0; bus.md_is_div_e = 0; bus.regwrite_m = 0; bus.memtoreg_m = 0;
    bus.regwrite_w = 0; bus.except_flush = 0;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    clear_inputs();
    bus.md_start_e = 1;
    #1;
    checks++; if (bus.md_busy !== 1'b1) begin errors++; $display("FAIL reset_busy_follows_start: got %b exp 1", bus.md_busy); end
    checks++; if (bus.md_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", bus.md_done); end
    checks++; if (bus.stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", bus.stall_cnt); end
    checks++; if ({bus.stall_f, bus.stall_e, bus.flush_e} !== 3'b110) begin errors++; $display("FAIL reset_stalls: got %b exp 110", {bus.stall_f, bus.stall_e, bus.flush_e}); end
    bus.md_start_e = 0;
    #1;
    checks++; if (bus.md_busy !== 1'b0) begin errors++; $display("FAIL reset_busy_low: got %b exp 0", bus.md_busy); end
    #10 resetn = 1;
  endtask

  task automatic test_forward;
    next_cycle();
    bus.rs_e = 8; bus.rt_e = 8; bus.wreg_e = 8; bus.regwrite_e = 1; bus.rs_d = 8;
    bus.wreg_m = 8; bus.regwrite_m = 1; bus.wreg_w = 8; bus.regwrite_w = 1;
    #1;
    checks++; if (bus.fwd_a_e !== 2'b10) begin errors++; $display("FAIL fwd_a_e_m: got %b exp 10", bus.fwd_a_e); end
    checks++; if (bus.fwd_b_e !== 2'b10) begin errors++; $display("FAIL fwd_b_e_m: got %b exp 10", bus.fwd_b_e); end
    checks++; if ({bus.fwd_a_d, bus.fwd_b_d} !== 2'b10) begin errors++; $display("FAIL fwd_d_m: got %b exp 10", {bus.fwd_a_d, bus.fwd_b_d}); end
    bus.regwrite_m = 0;
    #1;
    checks++; if (bus.fwd_a_e !== 2'b01) begin errors++; $display("FAIL fwd_a_e_w: got %b exp 01", bus.fwd_a_e); end
    checks++; if (bus.fwd_a_d !== 1'b0) begin errors++; $display("FAIL fwd_a_d_off: got %b exp 0", bus.fwd_a_d); end
    bus.rs_e = 0; bus.wreg_m = 0; bus.regwrite_m = 1; bus.wreg_w = 0;
    #1;
    checks++; if ({bus.fwd_a_e, bus.fwd_b_e} !== 4'b0000) begin errors++; $display("FAIL fwd_zero_reg: got %b exp 0000", {bus.fwd_a_e, bus.fwd_b_e}); end
    clear_inputs();
  endtask

  task automatic test_lw_stall;
    next_cycle();
    bus.memtoreg_e = 1; bus.regwrite_e = 1; bus.wreg_e = 9; bus.rt_d = 9;
    #1;
    checks++; if ({bus.stall_f, bus.stall_d, bus.flush_e, bus.stall_e, bus.flush_d} !== 5'b11100) begin errors++; $display("FAIL lw_stall: got %b exp 11100", {bus.stall_f, bus.stall_d, bus.flush_e, bus.stall_e, bus.flush_d}); end
    next_cycle();
    clear_inputs();
    #1;
    checks++; if (bus.stall_cnt !== 4'd1) begin errors++; $display("FAIL lw_cnt: got %0d exp 1", bus.stall_cnt); end
    bus.memtoreg_e = 1; bus.regwrite_e = 1; bus.wreg_e = 0; bus.rt_d = 0;
    #1;
    checks++; if ({bus.stall_f, bus.flush_e} !== 2'b00) begin errors++; $display("FAIL lw_zero_reg: got %b exp 00", {bus.stall_f, bus.flush_e}); end
    clear_inputs();
  endtask

  task automatic test_branch;
    next_cycle();
    bus.branch_d = 1; bus.rs_d = 5; bus.wreg_m = 5; bus.memtoreg_m = 1; bus.regwrite_m = 1;
    #1;
    checks++; if ({bus.stall_d, bus.flush_e, bus.stall_e} !== 3'b110) begin errors++; $display("FAIL br_load_m: got %b exp 110", {bus.stall_d, bus.flush_e, bus.stall_e}); end
    bus.memtoreg_m = 0;
    #1;
    checks++; if ({bus.stall_d, bus.fwd_a_d} !== 2'b01) begin errors++; $display("FAIL br_fwd_m: got %b exp 01", {bus.stall_d, bus.fwd_a_d}); end
    bus.branch_d = 0; bus.jr_d = 1; bus.regwrite_m = 0; bus.wreg_e = 5; bus.regwrite_e = 1;
    #1;
    checks++; if (bus.stall_d !== 1'b1) begin errors++; $display("FAIL jr_alu_e: got %b exp 1", bus.stall_d); end
    clear_inputs();
  endtask

  task automatic test_mul;
    next_cycle();
    bus.md_start_e = 1; bus.md_is_div_e = 0;
    bus.memtoreg_e = 1; bus.regwrite_e = 1; bus.wreg_e = 9; bus.rt_d = 9;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if ({bus.md_busy, bus.stall_f, bus.stall_d, bus.stall_e, bus.stall_m, bus.stall_w, bus.flush_e, bus.md_done} !== 8'b11111100) begin errors++; $display("FAIL mul_busy_%0d: got %b exp 11111100", i, {bus.md_busy, bus.stall_f, bus.stall_d, bus.stall_e, bus.stall_m, bus.stall_w, bus.flush_e, bus.md_done}); end
      next_cycle();
    end
    #1;
    checks++; if ({bus.md_busy, bus.stall_f, bus.stall_d, bus.stall_e, bus.stall_m, bus.stall_w, bus.flush_e, bus.md_done} !== 8'b01100011) begin errors++; $display("FAIL mul_done: got %b exp 01100011", {bus.md_busy, bus.stall_f, bus.stall_d, bus.stall_e, bus.stall_m, bus.stall_w, bus.flush_e, bus.md_done}); end
    clear_inputs();
    next_cycle();
    checks++; if ({bus.md_busy, bus.md_done} !== 2'b00) begin errors++; $display("FAIL mul_after: got %b exp 00", {bus.md_busy, bus.md_done}); end
    checks++; if (bus.stall_cnt !== 4'd5) begin errors++; $display("FAIL mul_cnt: got %0d exp 5", bus.stall_cnt); end
  endtask

  task automatic test_div_flush;
    logic seen_done = 0;
    next_cycle();
    bus.md_start_e = 1; bus.md_is_div_e = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if ({bus.md_busy, bus.stall_e, bus.md_done} !== 3'b110) begin errors++; $display("FAIL div_busy_%0d: got %b exp 110", i, {bus.md_busy, bus.stall_e, bus.md_done}); end
      next_cycle();
    end
    bus.except_flush = 1;
    #1;
    checks++; if ({bus.stall_f, bus.stall_d, bus.stall_e, bus.stall_m, bus.stall_w, bus.flush_d, bus.flush_e, bus.flush_m, bus.md_done} !== 9'b000001110) begin errors++; $display("FAIL div_flush: got %b exp 000001110", {bus.stall_f, bus.stall_d, bus.stall_e, bus.stall_m, bus.stall_w, bus.flush_d, bus.flush_e, bus.flush_m, bus.md_done}); end
    next_cycle();
    clear_inputs();
    #1;
    checks++; if ({bus.md_busy, bus.md_done} !== 2'b00) begin errors++; $display("FAIL div_idle: got %b exp 00", {bus.md_busy, bus.md_done}); end
    for (int i = 0; i < 40; i++) begin
      next_cycle();
      if (bus.md_done) seen_done = 1;
    end
    checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL div_no_done: got %b exp 0", seen_done); end
    checks++; if (bus.stall_cnt !== 4'd15) begin errors++; $display("FAIL div_cnt: got %0d exp 15", bus.stall_cnt); end
  endtask

  task automatic test_reset_mid_div;
    logic seen_done = 0;
    next_cycle();
    bus.md_start_e = 1; bus.md_is_div_e = 1;
    repeat (5) next_cycle();
    resetn = 0;
    #1;
    checks++; if ({bus.md_busy, bus.md_done} !== 2'b10) begin errors++; $display("FAIL rst_div_busy: got %b exp 10", {bus.md_busy, bus.md_done}); end
    checks++; if (bus.stall_cnt !== 4'd0) begin errors++; $display("FAIL rst_div_cnt: got %0d exp 0", bus.stall_cnt); end
    bus.md_start_e = 0;
    #1;
    checks++; if (bus.md_busy !== 1'b0) begin errors++; $display("FAIL rst_div_idle: got %b exp 0", bus.md_busy); end
    resetn = 1;
    for (int i = 0; i < 40; i++) begin
      next_cycle();
      if (bus.md_done) seen_done = 1;
    end
    checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL rst_div_no_done: got %b exp 0", seen_done); end
    clear_inputs();
  endtask

  task automatic test_saturate;
    next_cycle();
    bus.memtoreg_e = 1; bus.regwrite_e = 1; bus.wreg_e = 3; bus.rs_d = 3;
    for (int i = 1; i <= 20; i++) begin
      next_cycle();
      if (i == 10) begin
        checks++; if (bus.stall_cnt !== 4'd10) begin errors++; $display("FAIL sat_mid: got %0d exp 10", bus.stall_cnt); end
      end
    end
    checks++; if (bus.stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_top: got %0d exp 15", bus.stall_cnt); end
    next_cycle();
    checks++; if (bus.stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d exp 15", bus.stall_cnt); end
    #2 resetn = 0;
    #1;
    checks++; if (bus.stall_cnt !== 4'd0) begin errors++; $display("FAIL sat_async_rst: got %0d exp 0", bus.stall_cnt); end
    clear_inputs();
    resetn = 1;
  endtask

  initial begin
    test_reset();
    test_forward();
    test_lw_stall();
    test_branch();
    test_mul();
    test_div_flush();
    test_reset_mid_div();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
